bot_icon: RTL

//  Generates the 4-bit icon code consumed by the VGA colour stage for every

---
 rtl/bot_icon.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bot_icon.sv
// Robot sprite overlay: places a rotated 16x16 icon at the bot's latched world position and
// produces a 4-bit icon code two clocks after the pixel coordinates arrive.
module bot_icon #(
    parameter int unsigned ICON_SIZE    = 16,
    parameter int unsigned SCALE_X      = 8,
    parameter int unsigned SCALE_Y      = 6,
    parameter int unsigned V_ACTIVE     = 768,
    parameter int unsigned BLINK_FRAMES = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        video_on,
    input  logic [11:0] pixel_row,
    input  logic [11:0] pixel_column,
    input  logic [7:0]  LocX,
    input  logic [7:0]  LocY,
    input  logic [7:0]  BotInfo,
    output logic [3:0]  icon
);

    localparam int unsigned IW   = $clog2(ICON_SIZE);
    localparam int unsigned FC_W = $clog2(BLINK_FRAMES);

    localparam logic signed [12:0] W_SIZE = 13'(ICON_SIZE);
    localparam logic signed [12:0] W_HALF = 13'(ICON_SIZE / 2);

    // Row bitmaps, pixel 0 in the two MSBs; two bits per pixel.
    localparam logic [2*ICON_SIZE-1:0] ORTH [16] = '{
        32'h0003_C000, 32'h000F_F000, 32'h003F_FC00, 32'h0002_8000,
        32'h0555_5550, 32'h06AA_AA90, 32'h06EA_AB90, 32'h06AA_AA90,
        32'h06AB_EA90, 32'h06AA_AA90, 32'h06BF_FE90, 32'h06AA_AA90,
        32'h0555_5550, 32'h0140_0140, 32'h0540_0150, 32'h0000_0000
    };

    localparam logic [2*ICON_SIZE-1:0] DIAG [16] = '{
        32'h0000_00F0, 32'h0000_03F0, 32'h0000_0FC0, 32'h0001_5700,
        32'h0016_A500, 32'h016A_A900, 32'h05AB_AA40, 32'h16AA_AA40,
        32'h1AAF_AA40, 32'h1AAA_A900, 32'h1ABF_A900, 32'h06AA_A400,
        32'h01AA_9000, 32'h0055_4000, 32'h0050_0000, 32'h0000_0000
    };

    // Per-frame state
    logic [6:0]      r_loc_x;
    logic [6:0]      r_loc_y;
    logic [2:0]      r_heading;
    logic            r_stall;
    logic [FC_W-1:0] r_frame_cnt;
    logic            r_blink;

    // Pipeline
    logic            r_s1_show;
    logic [IW-1:0]   r_s1_u;
    logic [IW-1:0]   r_s1_v;
    logic [2:0]      r_s1_head;
    logic [3:0]      r_icon;

    logic                    w_latch;
    logic signed [12:0]      w_cx;
    logic signed [12:0]      w_cy;
    logic signed [12:0]      w_x0;
    logic signed [12:0]      w_y0;
    logic signed [12:0]      w_u;
    logic signed [12:0]      w_v;
    logic                    w_inside;
    logic                    w_show;
    logic [IW-1:0]           w_r;
    logic [IW-1:0]           w_c;
    logic [2*ICON_SIZE-1:0]  w_row;
    logic [1:0]              w_pix;
    logic                    w_unused;

    assign w_unused = ^{LocX[7], LocY[7], BotInfo[6:3]};

    assign w_latch = (pixel_row == 12'(V_ACTIVE)) && (pixel_column == 12'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_loc_x     <= '0;
            r_loc_y     <= '0;
            r_heading   <= '0;
            r_stall     <= 1'b0;
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_latch) begin
            r_loc_x   <= LocX[6:0];
            r_loc_y   <= LocY[6:0];
            r_heading <= BotInfo[2:0];
            r_stall   <= BotInfo[7];
            if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_frame_cnt <= r_frame_cnt + FC_W'(1);
            end
        end
    end

    assign w_cx = 13'({6'd0, r_loc_x} * 13'(SCALE_X) + 13'(SCALE_X / 2));
    assign w_cy = 13'({6'd0, r_loc_y} * 13'(SCALE_Y) + 13'(SCALE_Y / 2));
    assign w_x0 = w_cx - W_HALF;
    assign w_y0 = w_cy - W_HALF;

    // Signed offsets clip at the screen edges; nothing wraps into 0..15.
    assign w_u = $signed({1'b0, pixel_column}) - w_x0;
    assign w_v = $signed({1'b0, pixel_row}) - w_y0;

    assign w_inside = (w_u >= 13'sd0) && (w_u < W_SIZE) && (w_v >= 13'sd0) && (w_v < W_SIZE);
    assign w_show   = w_inside && video_on && !(r_stall && r_blink);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_show <= 1'b0;
            r_s1_u    <= '0;
            r_s1_v    <= '0;
            r_s1_head <= '0;
        end else begin
            r_s1_show <= w_show;
            r_s1_u    <= w_u[IW-1:0];
            r_s1_v    <= w_v[IW-1:0];
            r_s1_head <= r_heading;
        end
    end

    // Quarter-turn rotation by heading/2; ~x is (ICON_SIZE-1)-x.
    always_comb begin
        w_r = r_s1_v;
        w_c = r_s1_u;
        case (r_s1_head[2:1])
            2'd0: begin w_r = r_s1_v;  w_c = r_s1_u;  end
            2'd1: begin w_r = ~r_s1_u; w_c = r_s1_v;  end
            2'd2: begin w_r = ~r_s1_v; w_c = ~r_s1_u; end
            2'd3: begin w_r = r_s1_u;  w_c = ~r_s1_v; end
            default: begin w_r = r_s1_v; w_c = r_s1_u; end
        endcase
        w_row = r_s1_head[0] ? DIAG[w_r] : ORTH[w_r];
        w_pix = w_row[{~w_c, 1'b0} +: 2];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_icon <= 4'd0;
        end else begin
            r_icon <= r_s1_show ? {2'b00, w_pix} : 4'd0;
        end
    end

    assign icon = r_icon;

endmodule
